// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if: command handshake and JK bank feedback bundle for the sequencer
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             mismatch;

    modport master (output start, op, operand, count, q, input j, k, busy, done, mismatch);
    modport slave  (input start, op, operand, count, q, output j, k, busy, done, mismatch);
endinterface

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives j/k commands into a JK flip-flop bank and verifies the resulting value
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    jk_bank_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] expected;
    logic             illegal;

    function automatic logic is_count(input logic [2:0] o);
        return o == 3'd5 || o == 3'd6;
    endfunction

    // Toggle mask for one count step: a bit toggles when every lower bit is 1 (up) or 0 (down).
    function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] v, input logic down);
        logic [WIDTH-1:0] m;
        logic             c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = c;
            c    = c & (v[i] ^ down);
        end
        return m;
    endfunction

    // Packed {j, k} command for one RUN cycle.
    function automatic logic [2*WIDTH-1:0] command(input logic [2:0] o, input logic [WIDTH-1:0] opd,
                                                   input logic [WIDTH-1:0] v);
        case (o)
            3'd1:    return {opd, ~opd};
            3'd2:    return {opd, {WIDTH{1'b0}}};
            3'd3:    return {{WIDTH{1'b0}}, opd};
            3'd4:    return {opd, opd};
            3'd5:    return {2{step_mask(v, 1'b0)}};
            3'd6:    return {2{step_mask(v, 1'b1)}};
            default: return '0;
        endcase
    endfunction

    // Value the bank must hold once the whole operation has completed.
    function automatic logic [WIDTH-1:0] expect_of(input logic [2:0] o, input logic [WIDTH-1:0] opd,
                                                   input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] v);
        case (o)
            3'd1:    return opd;
            3'd2:    return v | opd;
            3'd3:    return v & ~opd;
            3'd4:    return v ^ opd;
            3'd5:    return v + WIDTH'(cnt);
            3'd6:    return v - WIDTH'(cnt);
            default: return v;
        endcase
    endfunction

    // Sequencer FSM; all outputs are registered and only RUN carries non-zero j/k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.j        <= '0;
            bus.k        <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.mismatch <= 1'b0;
            rem          <= '0;
            op_r         <= '0;
            expected     <= '0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_r         <= bus.op;
                    rem          <= bus.count;
                    expected     <= expect_of(bus.op, bus.operand, bus.count, bus.q);
                    illegal      <= bus.op == 3'd7;
                    bus.mismatch <= 1'b0;
                    bus.busy     <= 1'b1;
                    if (is_count(bus.op) && bus.count == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state            <= RUN;
                        {bus.j, bus.k}   <= command(bus.op, bus.operand, bus.q);
                    end
                end
                RUN: begin
                    bus.j <= '0;
                    bus.k <= '0;
                    state <= SETTLE;
                end
                SETTLE: if (is_count(op_r) && rem > CNT_W'(1)) begin
                    rem            <= rem - CNT_W'(1);
                    {bus.j, bus.k} <= command(op_r, '0, bus.q);
                    state          <= RUN;
                end else begin
                    rem          <= '0;
                    state        <= DONE;
                    bus.done     <= 1'b1;
                    bus.mismatch <= illegal || bus.q != expected;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: randomized and directed checks of the sequencer against a trace model
module tb_jk_bank_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] bank_q = 4'h0;
    logic [3:0] preset_val = 4'h0;
    logic       preset_en = 1'b0;
    logic [3:0] stuck = 4'h0;
    bit         check_en = 1'b0;
    logic       last_mis = 1'b0;
    int         total = 0;
    int         bad = 0;

    typedef struct packed {
        logic [3:0] j;
        logic [3:0] k;
        logic       busy;
        logic       done;
        logic       mis;
    } exp_t;
    exp_t exp_q[$];

    jk_bank_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.q = bank_q;

    // Flip-flop bank, with optional stuck-at-0 bits and a test-only preload.
    always @(posedge clk) begin
        if (preset_en) bank_q <= preset_val;
        else bank_q <= ((bus.j & ~bank_q) | (~bus.k & bank_q)) & ~stuck;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Per-cycle comparison against the expected output trace.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (check_en) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{j: 4'h0, k: 4'h0, busy: 1'b0, done: 1'b0, mis: last_mis};
            last_mis = e.mis;
            chk("cyc_j", bus.j, e.j);
            chk("cyc_k", bus.k, e.k);
            chk("cyc_busy", bus.busy, e.busy);
            chk("cyc_done", bus.done, e.done);
            chk("cyc_mismatch", bus.mismatch, e.mis);
        end
    end

    // Builds the cycle-by-cycle trace of one operation from its arithmetic meaning.
    task automatic model(input logic [2:0] o, input logic [3:0] opd, input logic [7:0] cnt,
                         input logic [3:0] q0, output logic [3:0] fin, output int n);
        logic [3:0] jj, kk, ideal, v, m;
        n = 0;
        if (o == 3'd5 || o == 3'd6) begin
            v = q0;
            for (int s = 0; s < int'(cnt); s++) begin
                m = (o == 3'd5) ? (v ^ (v + 4'd1)) : (v ^ (v - 4'd1));
                exp_q.push_back('{j: m, k: m, busy: 1'b1, done: 1'b0, mis: 1'b0});
                exp_q.push_back('{j: 4'h0, k: 4'h0, busy: 1'b1, done: 1'b0, mis: 1'b0});
                v = ((o == 3'd5) ? v + 4'd1 : v - 4'd1) & ~stuck;
                n += 2;
            end
            ideal = (o == 3'd5) ? q0 + cnt[3:0] : q0 - cnt[3:0];
            fin = v;
        end else begin
            jj = (o == 3'd1 || o == 3'd2 || o == 3'd4) ? opd : 4'h0;
            kk = (o == 3'd1) ? ~opd : (o == 3'd3 || o == 3'd4) ? opd : 4'h0;
            ideal = (o == 3'd1) ? opd : (o == 3'd2) ? (q0 | opd) : (o == 3'd3) ? (q0 & ~opd) :
                    (o == 3'd4) ? (q0 ^ opd) : q0;
            fin = ideal & ~stuck;
            exp_q.push_back('{j: jj, k: kk, busy: 1'b1, done: 1'b0, mis: 1'b0});
            exp_q.push_back('{j: 4'h0, k: 4'h0, busy: 1'b1, done: 1'b0, mis: 1'b0});
            n = 2;
        end
        exp_q.push_back('{j: 4'h0, k: 4'h0, busy: 1'b1, done: 1'b1, mis: (o == 3'd7) || fin != ideal});
        n++;
    endtask

    task automatic preset(input logic [3:0] v);
        @(negedge clk);
        preset_en = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    // One operation: issue, optionally spam start while busy and in DONE, wait for done.
    task automatic run(input logic [2:0] o, input logic [3:0] opd, input logic [7:0] cnt, input bit noise,
                       output int lat, output logic [3:0] fq, output logic [3:0] fj, output logic [3:0] fk);
        logic [3:0] fin;
        int n;
        @(negedge clk);
        model(o, opd, cnt, bank_q, fin, n);
        bus.start = 1'b1;
        bus.op = o;
        bus.operand = opd;
        bus.count = cnt;
        lat = -1;
        fj = 4'hx;
        fk = 4'hx;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                fj = bus.j;
                fk = bus.k;
                bus.start = noise;
                bus.op = 3'($urandom);
                bus.operand = 4'($urandom);
                bus.count = 8'($urandom);
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, n);
        chk("final_q", bank_q, fin);
        fq = bank_q;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int lat;
        logic [3:0] fq, fj, fk;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.operand = 4'h0;
        bus.count = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_mismatch", bus.mismatch, 1'b0);
        chk("rst_jk", {bus.j, bus.k}, 8'h00);
        rst = 1'b0;
        check_en = 1'b1;

        preset(4'b0000);
        run(3'd1, 4'b1010, 8'd0, 1'b0, lat, fq, fj, fk);
        chk("load_lat", lat, 3);
        chk("load_q", fq, 4'b1010);
        chk("load_j", fj, 4'b1010);
        chk("load_k", fk, 4'b0101);
        chk("load_mis", bus.mismatch, 1'b0);

        preset(4'b1110);
        run(3'd5, 4'h0, 8'd3, 1'b1, lat, fq, fj, fk);
        chk("up_lat", lat, 7);
        chk("up_q", fq, 4'b0001);

        preset(4'b0000);
        run(3'd6, 4'h0, 8'd2, 1'b1, lat, fq, fj, fk);
        chk("down_lat", lat, 5);
        chk("down_q", fq, 4'b1110);

        stuck = 4'b0100;
        preset(4'b0000);
        run(3'd4, 4'b0100, 8'd0, 1'b0, lat, fq, fj, fk);
        chk("stuck_lat", lat, 3);
        chk("stuck_q", fq, 4'b0000);
        repeat (3) @(negedge clk);
        chk("stuck_mis_held", bus.mismatch, 1'b1);
        stuck = 4'b0000;

        run(3'd5, 4'h0, 8'd0, 1'b1, lat, fq, fj, fk);
        chk("zero_lat", lat, 1);
        chk("zero_mis", bus.mismatch, 1'b0);

        run(3'd7, 4'hf, 8'd0, 1'b0, lat, fq, fj, fk);
        chk("illegal_mis", bus.mismatch, 1'b1);

        preset(4'b0011);
        @(negedge clk);
        model(3'd5, 4'h0, 8'd5, bank_q, fq, lat);
        bus.start = 1'b1;
        bus.op = 3'd5;
        bus.count = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        last_mis = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_jk", {bus.j, bus.k}, 8'h00);
        chk("midrst_done", bus.done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_bank", bank_q, 4'b0101);
        run(3'd5, 4'h0, 8'd1, 1'b0, lat, fq, fj, fk);
        chk("after_rst_lat", lat, 3);
        chk("after_rst_q", fq, 4'b0110);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2) == 0) preset(4'($urandom));
            run(3'($urandom), 4'($urandom), 8'($urandom_range(19)), 1'($urandom), lat, fq, fj, fk);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
